bus_uart: RTL and testbench

Memory-mapped UART peripheral on the processor core's data bus. It decodes a 16-byte window of the bus address space and serves the core's single-cycle load/store accesses, with combinational read data. It serialises transmit bytes through a small FIFO and deserialises received bytes into a one-byte holding register. Line format is fixed at 8N1, LSB first, with a runtime-programmable baud divisor.

---
 rtl/bus_uart.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_bus_uart.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: 16-byte register window, TX FIFO with serialiser,
// RX deserialiser with a one-byte holding register and sticky error flags.
module bus_uart #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned TX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic        tx,
    input  logic        rx
);

    localparam int unsigned AW = $clog2(TX_DEPTH);
    localparam int unsigned CW = $clog2(TX_DEPTH + 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] idx;
    logic       data_wr, div_wr, data_rd, stat_rd;

    assign sel     = (bus_address[31:4] == BASE_ADDR[31:4]);
    assign idx     = bus_address[3:2];
    assign data_wr = sel && bus_write && (idx == 2'd0);
    assign div_wr  = sel && bus_write && (idx == 2'd2);
    assign data_rd = sel && bus_read && (idx == 2'd0);
    assign stat_rd = sel && bus_read && (idx == 2'd1);

    logic unused_bits;
    assign unused_bits = ^{bus_address[1:0], bus_write_data[31:16]};

    // ------------------------------------------------------------------
    // Divisor
    // ------------------------------------------------------------------
    logic [15:0] div_q;
    logic [15:0] eff_div;

    assign eff_div = (div_q == 16'd0) ? 16'd1 : div_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
        end else if (div_wr) begin
            div_q <= bus_write_data[15:0];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          tx_full, tx_empty, push, tx_pop;

    assign tx_full  = (count_q == CW'(TX_DEPTH));
    assign tx_empty = (count_q == '0);
    // Fullness is judged on the registered count, so a same-edge pop never frees a slot.
    assign push     = data_wr && !tx_full;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus_write_data[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (tx_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(tx_pop);
        end
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_busy;

    assign tx_busy = (tx_state_q != TxIdle);
    assign tx      = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr_q];
                    tx_cnt_d   = eff_div - 16'd1;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = eff_div - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TxData: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = eff_div - 16'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == 16'd0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_mem[rd_ptr_q];
                        tx_cnt_d   = eff_div - 16'd1;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase

        unique case (tx_state_d)
            TxStart: tx_d = 1'b0;
            TxData:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and deserialiser
    // ------------------------------------------------------------------
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        rx_s, rx_fall;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [15:0] rx_half, rx_start_cnt;
    logic        rx_stop_ok, rx_stop_err;

    assign rx_s         = rx_sync_q;
    assign rx_fall      = rx_prev_q && !rx_sync_q;
    assign rx_half      = {1'b0, eff_div[15:1]};
    // Counter reaches zero on the cycle the sample is taken, so preload one less.
    assign rx_start_cnt = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_stop_ok  = 1'b0;
        rx_stop_err = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_fall) begin
                    rx_cnt_d   = rx_start_cnt;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_cnt_d   = eff_div - 16'd1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = RxData;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d   = eff_div - 16'd1;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_stop_ok  = rx_s;
                    rx_stop_err = !rx_s;
                    rx_state_d  = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ------------------------------------------------------------------
    // RX holding register and flags
    // ------------------------------------------------------------------
    logic [7:0] rx_byte_q;
    logic       rx_valid_q, rx_overrun_q, rx_frame_err_q;
    logic       rx_load, rx_ovr_set;

    // A DATA read in the same cycle frees the holding register for the new byte.
    assign rx_load    = rx_stop_ok && (!rx_valid_q || data_rd);
    assign rx_ovr_set = rx_stop_ok && rx_valid_q && !data_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_byte_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (data_rd) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_ovr_set) begin
                rx_overrun_q <= 1'b1;
            end else if (stat_rd) begin
                rx_overrun_q <= 1'b0;
            end
            if (rx_stop_err) begin
                rx_frame_err_q <= 1'b1;
            end else if (stat_rd) begin
                rx_frame_err_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [31:0] status;

    assign status = {19'd0, 5'(count_q), 2'd0, rx_frame_err_q, rx_overrun_q, rx_valid_q,
                     tx_busy, tx_empty, tx_full};

    always_comb begin
        bus_read_data = '0;
        if (sel && bus_read) begin
            unique case (idx)
                2'd0:    bus_read_data = {23'd0, rx_valid_q, rx_byte_q};
                2'd1:    bus_read_data = status;
                2'd2:    bus_read_data = {16'd0, div_q};
                default: bus_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: register table, directed TX/RX corner cases,
// and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_bus_uart;

    localparam logic [31:0] A_DATA = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_DIV  = 32'h8000_0008;
    localparam logic [31:0] A_IDX3 = 32'h8000_000C;
    localparam int          DEPTH  = 4;
    localparam int          HIST   = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic [31:0] bus_read_data;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic        tx;
    logic        rx = 1'b1;

    bus_uart #(
        .BASE_ADDR  (32'h8000_0000),
        .TX_DEPTH   (DEPTH),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus_address   (bus_address),
        .bus_write_data(bus_write_data),
        .bus_read_data (bus_read_data),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .tx            (tx),
        .rx            (rx)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    logic tx_hist [HIST];
    always @(posedge clock) cyc <= cyc + 1;
    // tx_hist[n] holds tx as it stands after rising edge n.
    always @(negedge clock) if (cyc < HIST) tx_hist[cyc] <= tx;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_bytes [$];

    typedef struct {
        logic [1:0]  op;     // 0 write, 1 read and compare, 2 address only (no strobe)
        logic [31:0] addr;
        logic [31:0] data;   // write data or expected read data
    } vec_t;
    vec_t vecs [18];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output int edge_n);
        bus_address    = a;
        bus_write_data = d;
        bus_write      = 1'b1;
        @(posedge clock);
        #1;
        bus_write = 1'b0;
        edge_n    = cyc;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus_address = a;
        bus_read    = 1'b1;
        #1;
        d = bus_read_data;
        @(posedge clock);
        #1;
        bus_read = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(name, d, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic tx_at(input int i);
        if (i < 0 || i >= HIST) return 1'bx;
        return tx_hist[i];
    endfunction

    // Frames in exp_bytes must appear back to back from edge 'first', each bit held eff cycles.
    task automatic check_frames(input int first, input int eff);
        int span;
        span = 10 * eff;
        check("tx_high_before_frame", 32'(tx_at(first - 1)), 32'd1);
        for (int f = 0; f < exp_bytes.size(); f++) begin
            int   bad;
            logic g_bad, w_bad;
            bad   = -1;
            g_bad = 1'b0;
            w_bad = 1'b0;
            for (int j = 0; j < span; j++) begin
                logic w, g;
                w = frame_bit(exp_bytes[f], j / eff);
                g = tx_at(first + f * span + j);
                if (g !== w && bad < 0) begin
                    bad   = j;
                    g_bad = g;
                    w_bad = w;
                end
            end
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL tx_frame %0d (byte 0x%02h): cycle %0d of frame got %b, expected %b",
                         f, exp_bytes[f], bad, g_bad, w_bad);
            end
        end
        check("tx_idle_after_frames", 32'(tx_at(first + exp_bytes.size() * span)), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        rx = 1'b0;
        cycles(d);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            cycles(d);
        end
        rx = stop;
        cycles(d);
        rx = 1'b1;
    endtask

    initial begin
        int          n, n0, a, d, eff, k;
        logic [31:0] s, w;
        logic [7:0]  b;

        vecs[0]  = '{2'd1, A_STAT,        32'h0000_0002};
        vecs[1]  = '{2'd1, A_DIV,         32'h0000_0364};
        vecs[2]  = '{2'd1, A_DATA,        32'h0000_0000};
        vecs[3]  = '{2'd1, A_IDX3,        32'h0000_0000};
        vecs[4]  = '{2'd2, A_DIV,         32'h0000_0000};
        vecs[5]  = '{2'd0, A_DIV,         32'hABCD_1234};
        vecs[6]  = '{2'd1, 32'h8000_000A, 32'h0000_1234};
        vecs[7]  = '{2'd0, A_STAT,        32'hFFFF_FFFF};
        vecs[8]  = '{2'd1, A_STAT,        32'h0000_0002};
        vecs[9]  = '{2'd0, A_IDX3,        32'h0000_0055};
        vecs[10] = '{2'd1, A_IDX3,        32'h0000_0000};
        vecs[11] = '{2'd0, 32'h8000_0010, 32'h0000_0077};
        vecs[12] = '{2'd0, 32'h8000_0018, 32'h0000_9999};
        vecs[13] = '{2'd1, 32'h8000_0010, 32'h0000_0000};
        vecs[14] = '{2'd1, 32'h8000_0018, 32'h0000_0000};
        vecs[15] = '{2'd1, 32'h0000_0008, 32'h0000_0000};
        vecs[16] = '{2'd1, A_DIV,         32'h0000_1234};
        vecs[17] = '{2'd1, A_STAT,        32'h0000_0002};

        cycles(4);
        reset = 1'b0;
        cycles(1);
        check("tx_after_reset", 32'(tx), 32'd1);

        for (int i = 0; i < 18; i++) begin
            string nm;
            nm = $sformatf("reg_vec_%0d", i);
            if (vecs[i].op == 2'd0) begin
                bus_wr(vecs[i].addr, vecs[i].data, n);
            end else if (vecs[i].op == 2'd1) begin
                rd_check(nm, vecs[i].addr, vecs[i].data);
            end else begin
                bus_address = vecs[i].addr;
                bus_read    = 1'b0;
                #1;
                check(nm, bus_read_data, vecs[i].data);
                cycles(1);
            end
        end

        // Single 0xA5 frame at divisor 4.
        bus_wr(A_DIV, 32'd4, n);
        bus_wr(A_DATA, 32'h0000_00A5, n);
        exp_bytes = '{8'hA5};
        wait_until(n + 40);
        rd_check("busy_in_last_stop_cycle", A_STAT, 32'h0000_0006);
        rd_check("idle_after_40_cycles", A_STAT, 32'h0000_0002);
        check_frames(n + 1, 4);

        // Burst of six stores: one goes straight to the shifter, four fill the FIFO.
        for (int i = 1; i <= 6; i++) begin
            bus_wr(A_DATA, 32'(i), k);
            if (i == 1) n0 = k;
        end
        rd_check("burst_full_status", A_STAT, 32'h0000_0405);
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        wait_until(n0 + 1 + 200 + 2);
        check_frames(n0 + 1, 4);
        rd_check("burst_drained", A_STAT, 32'h0000_0002);

        // Randomized TX bursts, including divisor 0 (acts as 1).
        for (int it = 0; it < 4; it++) begin
            int cnt;
            d   = $urandom_range(0, 5);
            eff = (d == 0) ? 1 : d;
            bus_wr(A_DIV, 32'(d), n);
            rd_check("div_readback", A_DIV, 32'(d));
            cnt = $urandom_range(1, 6);
            exp_bytes.delete();
            for (int i = 0; i < cnt; i++) begin
                w = $urandom;
                bus_wr(A_DATA, w, k);
                if (i == 0) n0 = k;
                if (exp_bytes.size() < DEPTH + 1) exp_bytes.push_back(w[7:0]);
            end
            wait_until(n0 + 1 + 10 * eff * exp_bytes.size() + 2);
            check_frames(n0 + 1, eff);
            rd_check("rand_tx_drained", A_STAT, 32'h0000_0002);
        end

        // RX at divisor 8: valid byte with latency window.
        bus_wr(A_DIV, 32'd8, n);
        a = cyc;
        fork
            send_rx(8'h3C, 1'b1, 8);
            begin
                wait_until(a + 4 + 72);
                bus_rd(A_STAT, s);
                check("rx_valid_not_early", 32'(s[3]), 32'd0);
                wait_until(a + 4 + 72 + 4);
                bus_rd(A_STAT, s);
                check("rx_valid_in_time", 32'(s[3]), 32'd1);
            end
        join
        cycles(4);
        rd_check("rx_data_first_read", A_DATA, 32'h0000_013C);
        rd_check("rx_data_second_read", A_DATA, 32'h0000_003C);

        // Overrun: second byte arrives while the first is unread.
        send_rx(8'h3C, 1'b1, 8);
        cycles(4);
        send_rx(8'h5A, 1'b1, 8);
        cycles(4);
        rd_check("rx_overrun_status", A_STAT, 32'h0000_001A);
        rd_check("rx_overrun_cleared", A_STAT, 32'h0000_000A);
        rd_check("rx_overrun_kept_byte", A_DATA, 32'h0000_013C);
        rd_check("rx_overrun_valid_clr", A_DATA, 32'h0000_003C);

        // Framing error: stop bit low.
        send_rx(8'h77, 1'b0, 8);
        cycles(4);
        rd_check("rx_frame_err_status", A_STAT, 32'h0000_0022);
        rd_check("rx_frame_err_cleared", A_STAT, 32'h0000_0002);
        rd_check("rx_frame_err_no_load", A_DATA, 32'h0000_003C);

        // Two-cycle glitch is a false start.
        rx = 1'b0;
        cycles(2);
        rx = 1'b1;
        cycles(20);
        rd_check("rx_glitch_status", A_STAT, 32'h0000_0002);
        rd_check("rx_glitch_data", A_DATA, 32'h0000_003C);

        // Randomized RX bytes at random divisors.
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(4, 10);
            bus_wr(A_DIV, 32'(d), n);
            b = 8'($urandom);
            send_rx(b, 1'b1, d);
            cycles(4);
            rd_check("rand_rx_valid", A_DATA, {23'd0, 1'b1, b});
            rd_check("rand_rx_cleared", A_DATA, {23'd0, 1'b0, b});
        end

        // Reset in the middle of a frame with a byte still queued.
        bus_wr(A_DIV, 32'd4, n);
        bus_wr(A_DATA, 32'h0000_0000, n);
        bus_wr(A_DATA, 32'h0000_0000, n0);
        cycles(8);
        check("tx_low_mid_frame", 32'(tx), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n = cyc;
        check("tx_high_after_reset_edge", 32'(tx), 32'd1);
        rd_check("status_after_mid_reset", A_STAT, 32'h0000_0002);
        rd_check("div_after_mid_reset", A_DIV, 32'h0000_0364);
        cycles(60);
        k = 0;
        for (int i = n; i < n + 60; i++) if (tx_at(i) !== 1'b1) k++;
        check("tx_stays_idle_after_reset", 32'(k), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
